// File: rtl/apb_req_arbiter_pkg.sv
// Shared definitions for the APB requester arbiter: state encoding and the
// round-robin pick used by the picker sub-module.
package apb_arb_pkg;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    // Scan upward from last+1 (wrapping at nreq) and return the first
    // requester with a pending request; the caller qualifies with "any".
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last,
                                           input int         nreq);
        logic [1:0] idx;
        logic       found;
        int         c;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= nreq) begin
                c = (int'(last) + k) % nreq;
                if (!found && req[c[1:0]]) begin
                    idx   = c[1:0];
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Bridge-side bundle: requester request/response lanes plus the APB master
// command inputs and status returns.
interface apb_req_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
);
    // Requests: req_valid is a level held with stable fields until the
    // matching req_ready pulse; a request dropped before that gets no reply.
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_write;
    logic [NREQ*(WIDTH+1)-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]    req_wdata;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0]          rsp_valid;
    logic                     rsp_err;
    logic [WIDTH-1:0]         rsp_rdata;
    logic                     transfer;
    logic                     read_write;
    logic [WIDTH:0]           write_paddr;
    logic [WIDTH:0]           read_paddr;
    logic [WIDTH-1:0]         write_data;
    logic                     PENABLE;
    logic                     PREADY;
    logic                     PSLVERR;
    logic [WIDTH-1:0]         read_data_out;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  transfer, read_write, write_paddr, read_paddr, write_data,
        output PENABLE, PREADY, PSLVERR, read_data_out
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output transfer, read_write, write_paddr, read_paddr, write_data,
        input  PENABLE, PREADY, PSLVERR, read_data_out
    );

endinterface

// File: rtl/apb_req_arbiter_picker.sv
// Combinational round-robin picker: one-hot grant, its index, and whether
// any requester is pending.
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    logic [3:0] w_req4;
    logic [1:0] w_last2;
    logic [1:0] w_idx2;

    always_comb begin
        w_req4                = '0;
        w_req4[NREQ-1:0]      = i_req;
        w_last2               = '0;
        w_last2[IDXW-1:0]     = i_last;
    end

    assign w_idx2 = rr_pick(w_req4, w_last2, NREQ);
    assign o_idx  = w_idx2[IDXW-1:0];
    assign o_any  = |i_req;

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_grant[i] = o_any && (o_idx == IDXW'(i));
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NREQ requesters; latches
// the granted command and supports back-to-back transfers.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    apb_req_arbiter_if.slave bus,
    output logic [0:0]      o_dbg_state
);

    localparam int AW   = WIDTH + 1;
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [0:0]       r_state;
    logic [IDXW-1:0]  r_rr_last;
    logic [IDXW-1:0]  r_hold_idx;
    logic             r_hold_write;
    logic [AW-1:0]    r_hold_addr;
    logic [WIDTH-1:0] r_hold_wdata;
    logic [NREQ-1:0]  r_rsp_valid;
    logic             r_rsp_err;
    logic [WIDTH-1:0] r_rsp_rdata;

    logic [NREQ-1:0]  w_grant;
    logic [IDXW-1:0]  w_idx;
    logic             w_any;
    logic             w_busy;
    logic             w_done;
    logic             w_abrt;
    logic             w_take;

    apb_rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
        .i_req   (bus.req_valid),
        .i_last  (r_rr_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_busy = (r_state == ARB_BUSY);
    assign w_done = w_busy & bus.PENABLE & bus.PREADY;
    assign w_abrt = w_busy & bus.PSLVERR & ~w_done;
    // A new grant is only possible from IDLE or in the completion cycle.
    assign w_take = (~w_busy | w_done) & w_any;

    // Reset gates the accept pulse so every output reads 0 while PRESETn is low.
    assign bus.req_ready = (w_take && PRESETn) ? w_grant : '0;
    // Dropping transfer in the final done cycle (or on abort) keeps the
    // master from launching a repeat of the completed command.
    assign bus.transfer    = w_busy & ~((w_done & ~w_any) | w_abrt);
    assign bus.read_write  = w_busy & r_hold_write;
    assign bus.write_paddr = w_busy ? r_hold_addr  : '0;
    assign bus.read_paddr  = w_busy ? r_hold_addr  : '0;
    assign bus.write_data  = w_busy ? r_hold_wdata : '0;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign o_dbg_state     = r_state;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= ARB_IDLE;
            r_rr_last    <= IDXW'(NREQ - 1);
            r_hold_idx   <= '0;
            r_hold_write <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
        end else begin
            if (w_take) begin
                r_state      <= ARB_BUSY;
                r_rr_last    <= w_idx;
                r_hold_idx   <= w_idx;
                r_hold_write <= bus.req_write[w_idx];
                r_hold_addr  <= bus.req_addr[int'(w_idx)*AW +: AW];
                r_hold_wdata <= bus.req_wdata[int'(w_idx)*WIDTH +: WIDTH];
            end else if (w_done || w_abrt) begin
                r_state <= ARB_IDLE;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_done || w_abrt) begin
                r_rsp_valid[r_hold_idx] <= 1'b1;
                r_rsp_err               <= w_abrt;
            end
            if (w_done && !r_hold_write) begin
                r_rsp_rdata <= bus.read_data_out;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: APB master responses are driven cycle
// by cycle and every output is compared with hand-computed values.
module tb_apb_req_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 2;

    logic       PCLK;
    logic       PRESETn;
    logic [0:0] dbg_state;

    int n_tests;
    int n_fail;

    apb_req_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    apb_req_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic apb(input logic pen, input logic prdy, input logic perr);
        bus.PENABLE = pen;
        bus.PREADY  = prdy;
        bus.PSLVERR = perr;
    endtask

    task automatic clear_inputs();
        bus.req_valid     = '0;
        bus.req_write     = '0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.read_data_out = '0;
        apb(1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(negedge PCLK);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        PRESETn = 1'b0;
        clear_inputs();
        repeat (2) cyc();
        settle();
        chk("rst_state",    64'(dbg_state),       64'h0);
        chk("rst_transfer", 64'(bus.transfer),    64'h0);
        chk("rst_ready",    64'(bus.req_ready),   64'h0);
        chk("rst_rsp",      64'(bus.rsp_valid),   64'h0);
        chk("rst_paddr",    64'(bus.write_paddr), 64'h0);
        cyc();
        PRESETn = 1'b1;

        // single write from req0
        cyc();
        bus.req_valid = 2'b01;
        bus.req_write = 2'b01;
        bus.req_addr  = {33'h0, 33'h1_0000_0010};
        bus.req_wdata = {32'h0, 32'hA5A5_A5A5};
        settle();
        chk("t1_ready",     64'(bus.req_ready), 64'h1);
        chk("t1_xfer_c0",   64'(bus.transfer),  64'h0);
        cyc();
        bus.req_valid = 2'b00;
        settle();
        chk("t1_xfer_c1",   64'(bus.transfer),    64'h1);
        chk("t1_rw",        64'(bus.read_write),  64'h1);
        chk("t1_wpaddr",    64'(bus.write_paddr), 64'h1_0000_0010);
        chk("t1_rpaddr",    64'(bus.read_paddr),  64'h1_0000_0010);
        chk("t1_wdata",     64'(bus.write_data),  64'hA5A5_A5A5);
        chk("t1_ready_off", 64'(bus.req_ready),   64'h0);
        cyc();
        apb(1'b1, 1'b1, 1'b0);
        settle();
        chk("t1_xfer_done", 64'(bus.transfer), 64'h0);
        chk("t1_state_c2",  64'(dbg_state),    64'h1);
        cyc();
        apb(1'b0, 1'b0, 1'b0);
        settle();
        chk("t1_rsp",       64'(bus.rsp_valid),   64'h1);
        chk("t1_err",       64'(bus.rsp_err),     64'h0);
        chk("t1_idle",      64'(dbg_state),       64'h0);
        chk("t1_paddr_idl", 64'(bus.write_paddr), 64'h0);
        cyc();
        settle();
        chk("t1_rsp_clr",   64'(bus.rsp_valid), 64'h0);

        // read from req1 with three wait states
        cyc();
        bus.req_valid = 2'b10;
        bus.req_write = 2'b00;
        bus.req_addr  = {33'h0_0000_0004, 33'h0};
        settle();
        chk("t2_ready", 64'(bus.req_ready), 64'h2);
        cyc();
        bus.req_valid = 2'b00;
        settle();
        chk("t2_xfer_setup", 64'(bus.transfer),   64'h1);
        chk("t2_rpaddr",     64'(bus.read_paddr), 64'h4);
        chk("t2_rw",         64'(bus.read_write), 64'h0);
        for (int w = 0; w < 3; w++) begin
            cyc();
            apb(1'b1, 1'b0, 1'b0);
            settle();
            chk("t2_xfer_wait", 64'(bus.transfer),  64'h1);
            chk("t2_rsp_wait",  64'(bus.rsp_valid), 64'h0);
        end
        cyc();
        apb(1'b1, 1'b1, 1'b0);
        bus.read_data_out = 32'h1234_5678;
        settle();
        chk("t2_xfer_done", 64'(bus.transfer), 64'h0);
        cyc();
        apb(1'b0, 1'b0, 1'b0);
        bus.read_data_out = 32'h0;
        settle();
        chk("t2_rsp",   64'(bus.rsp_valid), 64'h2);
        chk("t2_rdata", 64'(bus.rsp_rdata), 64'h1234_5678);
        chk("t2_err",   64'(bus.rsp_err),   64'h0);

        // contention: both requesters continuously valid
        cyc();
        bus.req_valid = 2'b11;
        bus.req_write = 2'b11;
        bus.req_addr  = {33'h1_0000_0020, 33'h0_0000_0030};
        bus.req_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        settle();
        chk("t3_ready_c0", 64'(bus.req_ready), 64'h1);
        chk("t3_xfer_c0",  64'(bus.transfer),  64'h0);
        cyc();
        settle();
        chk("t3_xfer_c1",  64'(bus.transfer),   64'h1);
        chk("t3_wdata_c1", 64'(bus.write_data), 64'hAAAA_0000);
        chk("t3_ready_c1", 64'(bus.req_ready),  64'h0);
        for (int r = 0; r < 3; r++) begin
            cyc();
            apb(1'b1, 1'b1, 1'b0);
            settle();
            chk("t3_xfer_done", 64'(bus.transfer),  64'h1);
            chk("t3_ready_alt", 64'(bus.req_ready), (r % 2 == 0) ? 64'h2 : 64'h1);
            cyc();
            apb(1'b0, 1'b0, 1'b0);
            settle();
            chk("t3_state_busy", 64'(dbg_state),      64'h1);
            chk("t3_rsp_alt",    64'(bus.rsp_valid),  (r % 2 == 0) ? 64'h1 : 64'h2);
            chk("t3_wdata_alt",  64'(bus.write_data), (r % 2 == 0) ? 64'hBBBB_0001 : 64'hAAAA_0000);
            chk("t3_xfer_setup", 64'(bus.transfer),   64'h1);
        end
        cyc();
        bus.req_valid = 2'b00;
        apb(1'b1, 1'b1, 1'b0);
        settle();
        chk("t3_xfer_last",  64'(bus.transfer),  64'h0);
        chk("t3_ready_last", 64'(bus.req_ready), 64'h0);
        cyc();
        apb(1'b0, 1'b0, 1'b0);
        settle();
        chk("t3_rsp_last", 64'(bus.rsp_valid), 64'h2);
        chk("t3_idle",     64'(dbg_state),     64'h0);

        // error abort during setup
        cyc();
        bus.req_valid = 2'b01;
        bus.req_write = 2'b01;
        bus.req_addr  = {33'h0, 33'h0_0000_0040};
        bus.req_wdata = {32'h0, 32'h0};
        settle();
        chk("t4_ready", 64'(bus.req_ready), 64'h1);
        cyc();
        bus.req_valid = 2'b00;
        apb(1'b0, 1'b0, 1'b1);
        settle();
        chk("t4_xfer_abrt", 64'(bus.transfer), 64'h0);
        cyc();
        apb(1'b0, 1'b0, 1'b0);
        settle();
        chk("t4_rsp",  64'(bus.rsp_valid), 64'h1);
        chk("t4_err",  64'(bus.rsp_err),   64'h1);
        chk("t4_idle", 64'(dbg_state),     64'h0);

        // last request: no repeat transfer afterwards
        cyc();
        bus.req_valid = 2'b10;
        bus.req_write = 2'b00;
        bus.req_addr  = {33'h0_0000_0008, 33'h0};
        settle();
        chk("t5_ready", 64'(bus.req_ready), 64'h2);
        cyc();
        bus.req_valid = 2'b00;
        settle();
        chk("t5_xfer_setup", 64'(bus.transfer), 64'h1);
        cyc();
        apb(1'b1, 1'b1, 1'b0);
        bus.read_data_out = 32'hCAFE_F00D;
        settle();
        chk("t5_xfer_done", 64'(bus.transfer), 64'h0);
        cyc();
        apb(1'b0, 1'b0, 1'b0);
        bus.read_data_out = 32'h0;
        settle();
        chk("t5_xfer_after", 64'(bus.transfer),  64'h0);
        chk("t5_rsp",        64'(bus.rsp_valid), 64'h2);
        chk("t5_rdata",      64'(bus.rsp_rdata), 64'hCAFE_F00D);
        chk("t5_err_clear",  64'(bus.rsp_err),   64'h0);
        cyc();
        settle();
        chk("t5_xfer_idle", 64'(bus.transfer), 64'h0);
        chk("t5_idle",      64'(dbg_state),    64'h0);

        // reset in the middle of an access
        cyc();
        bus.req_valid = 2'b01;
        bus.req_write = 2'b11;
        bus.req_addr  = {33'h1_0000_0050, 33'h1_0000_0060};
        bus.req_wdata = {32'h2222_2222, 32'h1111_1111};
        settle();
        chk("t6_ready", 64'(bus.req_ready), 64'h1);
        cyc();
        bus.req_valid = 2'b11;
        settle();
        chk("t6_xfer_setup", 64'(bus.transfer), 64'h1);
        cyc();
        apb(1'b1, 1'b0, 1'b0);
        settle();
        chk("t6_xfer_wait", 64'(bus.transfer), 64'h1);
        PRESETn = 1'b0;
        settle();
        chk("t6_rst_xfer",  64'(bus.transfer),    64'h0);
        chk("t6_rst_ready", 64'(bus.req_ready),   64'h0);
        chk("t6_rst_wdata", 64'(bus.write_data),  64'h0);
        chk("t6_rst_paddr", 64'(bus.write_paddr), 64'h0);
        chk("t6_rst_rw",    64'(bus.read_write),  64'h0);
        chk("t6_rst_state", 64'(dbg_state),       64'h0);
        chk("t6_rst_rsp",   64'(bus.rsp_valid),   64'h0);
        cyc();
        apb(1'b0, 1'b0, 1'b0);
        PRESETn = 1'b1;
        settle();
        chk("t6_rel_ready", 64'(bus.req_ready), 64'h1);
        chk("t6_rel_rsp",   64'(bus.rsp_valid), 64'h0);
        cyc();
        bus.req_valid = 2'b00;
        settle();
        chk("t6_xfer2",  64'(bus.transfer),   64'h1);
        chk("t6_wdata2", 64'(bus.write_data), 64'h1111_1111);
        chk("t6_rsp2",   64'(bus.rsp_valid),  64'h0);
        cyc();
        apb(1'b1, 1'b1, 1'b0);
        settle();
        chk("t6_xfer_done", 64'(bus.transfer), 64'h0);
        cyc();
        apb(1'b0, 1'b0, 1'b0);
        settle();
        chk("t6_rsp_final", 64'(bus.rsp_valid), 64'h1);
        chk("t6_idle",      64'(dbg_state),     64'h0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
